// File: rtl/sync_bus_ram.sv
// sync_bus_ram: single-port word memory behind a simple strobe/response bus.
// A request is a one-cycle en strobe; the response is a one-cycle ready pulse
// after LATENCY wait cycles, carrying read data or an error flag.
//
// Handshake: en is a request strobe sampled on the rising edge while the FSM
// is IDLE or RESP (there is no backpressure and en is ignored in WAIT); every
// accepted request produces exactly one ready pulse. error and data_out are
// only meaningful while ready=1 and are held at zero otherwise.
module sync_bus_ram #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    write_en,
    input  logic [DATA_WIDTH/8-1:0] write_sel,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    ready,
    output logic                    error,
    output logic [1:0]              state_dbg
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              count;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    we_q;
    logic [BYTES-1:0]        sel_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    // Request fields used at the edge that enters RESP: live inputs when the
    // response is immediate, captured copies when coming out of WAIT.
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_data;
    logic                    c_we;
    logic [BYTES-1:0]        c_sel;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    fault;
    logic                    accept;
    logic                    go_resp;

    assign state_dbg = state;

    // Select the request source and classify it (alignment, range, timing).
    always_comb begin
        c_addr       = addr;
        c_data       = data_in;
        c_we         = write_en;
        c_sel        = write_sel;
        if (state == WAIT) begin
            c_addr = addr_q;
            c_data = data_q;
            c_we   = we_q;
            c_sel  = sel_q;
        end
        word_idx     = c_addr >> OFF_W;
        mem_idx      = word_idx[IDX_W-1:0];
        misaligned   = (c_addr & ADDR_WIDTH'(BYTES - 1)) != '0;
        out_of_range = word_idx >= ADDR_WIDTH'(DEPTH_WORDS);
        fault        = misaligned | out_of_range;
        // rst gates acceptance so nothing commits on an edge seen during reset.
        accept       = rst && en && ((state == IDLE) || (state == RESP));
        go_resp      = (accept && (LATENCY == 0)) ||
                       (rst && (state == WAIT) && (count == 4'd1));
    end

    // Byte-lane write commit on the edge entering RESP; never reset.
    always_ff @(posedge clk) begin
        if (go_resp && c_we && !fault) begin
            for (int i = 0; i < BYTES; i++) begin
                if (c_sel[i]) begin
                    mem[mem_idx][8*i +: 8] <= c_data[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= 4'd0;
            ready    <= 1'b0;
            error    <= 1'b0;
            data_out <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
        end else begin
            ready    <= go_resp;
            error    <= go_resp && fault;
            data_out <= (go_resp && !fault && !c_we) ? mem[mem_idx] : '0;
            case (state)
                IDLE, RESP: begin
                    if (en) begin
                        addr_q <= addr;
                        data_q <= data_in;
                        we_q   <= write_en;
                        sel_q  <= write_sel;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= 4'(LATENCY);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= 4'd0;
                end
            endcase
        end
    end

endmodule
